// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencing controller for the 5-stage RV32 core.
//
// Turns every stall/flush cause into one prioritised set of per-stage hold
// and bubble strobes. The causes are load-use interlock, multi-cycle mul/div
// occupancy of E, data-memory wait states in M, and taken-branch redirect.
// It also keeps a saturating count of fetch-stall cycles.
//
// Ports
//   clk, rst               core clock, synchronous active-high reset
//   rs1D/rs2D, useRs1D/2D  Decode source registers and their use flags
//   rdE, regwriteE,        Execute destination, writes the RF,
//   memtoregE              Execute instruction is a load
//   mdStartE, mdDone       multi-cycle op present in E / result valid pulse
//   branchTakenE           taken branch/jump resolved in E
//   dmemReqM, dmemReadyM   active data access in M / access completes
//   stallF..stallM         hold the pipeline register
//   flushD, flushE         load a bubble into the D / E register
//   bubbleM, bubbleW       load a bubble into the M / W register
//   mdGo                   one-cycle start strobe to the mul/div unit
//   mdBusy                 controller is waiting on mul/div
//   stallCount             cycles with stallF=1, saturating
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int RFIDX_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [RFIDX_W-1:0] rs1D,
   input  logic [RFIDX_W-1:0] rs2D,
   input  logic               useRs1D,
   input  logic               useRs2D,
   input  logic [RFIDX_W-1:0] rdE,
   input  logic               regwriteE,
   input  logic               memtoregE,
   input  logic               mdStartE,
   input  logic               mdDone,
   input  logic               branchTakenE,
   input  logic               dmemReqM,
   input  logic               dmemReadyM,
   output logic               stallF,
   output logic               stallD,
   output logic               stallE,
   output logic               stallM,
   output logic               flushD,
   output logic               flushE,
   output logic               bubbleM,
   output logic               bubbleW,
   output logic               mdGo,
   output logic               mdBusy,
   output logic [CNT_W-1:0]   stallCount
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic memWait;
   logic loadUse;

   assign memWait = dmemReqM & ~dmemReadyM;

   // x0 is never a real producer, so a load into x0 cannot create a hazard.
   assign loadUse = regwriteE & memtoregE & (rdE != '0) &
                    ((useRs1D & (rs1D == rdE)) | (useRs2D & (rs2D == rdE)));

   // ------------------------------------------------------------------
   // Next-state and strobe decode. Everything is forced low during
   // reset so a reset landing mid-operation cannot leak a strobe.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      stallF  = 1'b0;
      stallD  = 1'b0;
      stallE  = 1'b0;
      stallM  = 1'b0;
      flushD  = 1'b0;
      flushE  = 1'b0;
      bubbleM = 1'b0;
      bubbleW = 1'b0;
      mdGo    = 1'b0;
      mdBusy  = 1'b0;

      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (memWait) begin
                  // Freeze F..M; W drains with a bubble so the stalled
                  // access cannot retire twice.
                  stallF  = 1'b1;
                  stallD  = 1'b1;
                  stallE  = 1'b1;
                  stallM  = 1'b1;
                  bubbleW = 1'b1;
                  state_d = MEM_WAIT;
               end else if (mdStartE) begin
                  mdGo    = 1'b1;
                  stallF  = 1'b1;
                  stallD  = 1'b1;
                  stallE  = 1'b1;
                  bubbleM = 1'b1;
                  state_d = MD_WAIT;
               end else if (branchTakenE) begin
                  // The D instruction is wrong-path, so its load-use
                  // hazard is irrelevant and must not stall.
                  flushD = 1'b1;
                  flushE = 1'b1;
               end else if (loadUse) begin
                  // One-cycle hold of F/D with a bubble into E; the
                  // following cycle re-evaluates with the load in M.
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushE = 1'b1;
               end
            end

            MEM_WAIT: begin
               // Other causes are held off until the access finishes.
               if (dmemReadyM) begin
                  state_d = RUN;
               end else begin
                  stallF  = 1'b1;
                  stallD  = 1'b1;
                  stallE  = 1'b1;
                  stallM  = 1'b1;
                  bubbleW = 1'b1;
               end
            end

            MD_WAIT: begin
               // M holds a bubble here, so no memory wait can arise, and
               // mdStartE staying high must not restart the unit.
               mdBusy = 1'b1;
               if (mdDone) begin
                  state_d = RUN;
               end else begin
                  stallF  = 1'b1;
                  stallD  = 1'b1;
                  stallE  = 1'b1;
                  bubbleM = 1'b1;
               end
            end

            default: state_d = RUN;
         endcase
      end
   end

   // Saturating fetch-stall counter. stallF is already low during reset.
   always_comb begin
      cnt_d = cnt_q;
      if (stallF && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stallCount = cnt_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage RV32 core (F/D/E/M/W). It consolidates every stall and flush cause into one prioritised set of per-stage hold and bubble strobes, covering:
- load-use interlock;
- multi-cycle mul/div occupancy of Execute;
- data-memory wait states in Memory;
- taken-branch redirect.

It replaces ad-hoc stall wiring between the hazard detector and the pipeline registers. It exposes a saturating stall-cycle counter for performance monitoring.

## Interface

Parameters:
- RFIDX_W, 5, register-file index width
- CNT_W, 32, stall counter width

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- rs1D  in  RFIDX_W  Decode source register 1
- rs2D  in  RFIDX_W  Decode source register 2
- useRs1D  in  1  Decode instruction reads rs1
- useRs2D  in  1  Decode instruction reads rs2
- rdE  in  RFIDX_W  Execute destination register
- regwriteE  in  1  Execute instruction writes the register file
- memtoregE  in  1  Execute instruction is a load
- mdStartE  in  1  Execute holds a multi-cycle mul/div op
- mdDone  in  1  mul/div result valid (single-cycle pulse)
- branchTakenE  in  1  Execute resolved a taken branch/jump
- dmemReqM  in  1  Memory stage has an active data access
- dmemReadyM  in  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  out  1  hold the corresponding pipeline register
- flushD, flushE  out  1  load a bubble into the D / E register
- bubbleM, bubbleW  out  1  load a bubble into the M / W register
- mdGo  out  1  one-cycle start strobe to the mul/div unit
- mdBusy  out  1  FSM in MD_WAIT
- stallCount  out  CNT_W  cycles with stallF=1, saturating

## Operation

FSM states are RUN, MD_WAIT and MEM_WAIT. The reset state is RUN.

Definitions:
- memWait = dmemReqM & !dmemReadyM.
- loadUse = regwriteE & memtoregE & (rdE != 0) & ((useRs1D & rs1D == rdE) | (useRs2D & rs2D == rdE)).

Priority in RUN is memWait > mdStartE > branchTakenE > loadUse.
- memWait:
  - asserts stallF, stallD, stallE, stallM and bubbleW;
  - next state MEM_WAIT.
- mdStartE (no memWait):
  - asserts mdGo, stallF, stallD, stallE and bubbleM;
  - next state MD_WAIT.
- branchTakenE:
  - asserts flushD and flushE;
  - no stalls;
  - loadUse is suppressed, because the D instruction is wrong-path.
- loadUse alone:
  - asserts stallF, stallD and flushE;
  - lasts one cycle; the next cycle re-evaluates.
- No condition: all strobes 0.

In MEM_WAIT:
- While !dmemReadyM: stallF, stallD, stallE, stallM and bubbleW.
- On dmemReadyM: all stalls drop that cycle; next state RUN.
- Branch, load-use and mul/div causes are ignored until exit.

In MD_WAIT:
- mdBusy = 1.
- While !mdDone: stallF, stallD, stallE and bubbleM.
- On mdDone: stalls drop in the same cycle, E advances, and the next state is RUN.
- mdGo is never reasserted for the same op.
- memWait arising in M is impossible here, because M holds a bubble.

Other rules:
- mdDone in RUN or MEM_WAIT is ignored.
- flushD/flushE are never asserted in the same cycle as stallD/stallE, except for the loadUse combination (stallD with flushE).

stallCount:
- Increments by 1 on every cycle with stallF=1 and rst=0.
- Holds at 2^CNT_W-1.

## Timing

- Strobes are combinational (Mealy) from the registered state plus current inputs, and are valid in the same cycle as the cause.
- The state and stallCount update on the rising edge of clk.
- Reset values:
  - state RUN;
  - stallCount 0;
  - while rst=1, all strobes are forced to 0 and mdGo = 0.
- Reset in MD_WAIT or MEM_WAIT: back to RUN next edge. No mdGo is issued in the reset cycle.
- Latency:
  - mdGo is a single pulse, asserted in the first cycle mdStartE is seen.
  - The minimum MD_WAIT dwell is 1 cycle (mdDone in the cycle after mdGo).
- Load-use costs exactly 1 bubble. Branch costs 2 bubbles (D and E).

## Test plan

- Load-use:
  - Stimulus: regwriteE=1, memtoregE=1, rdE=5, rs2D=5, useRs2D=1 for 1 cycle.
  - Response: stallF=stallD=flushE=1 for that cycle only; stallCount goes 0->1.
  - Repeat with rdE=0: no strobes.
- Mul/div:
  - Stimulus: mdStartE held high; mdDone pulses 4 cycles later.
  - Response: mdGo=1 on cycle 0 only; mdBusy=1 on cycles 1-4; stallF/D/E and bubbleM on cycles 0-3; all 0 on cycle 4; state RUN; stallCount=4.
- Memory wait:
  - Stimulus: dmemReqM=1, dmemReadyM=0 for 3 cycles, then 1.
  - Response: stallF/D/E/M and bubbleW for 3 cycles; released on cycle 3.
  - Repeat with simultaneous branchTakenE=1: no flush until exit.
- Branch vs load-use:
  - Stimulus: branchTakenE=1 with loadUse true.
  - Response: flushD=flushE=1; stallF=stallD=0.
- Reset mid-op:
  - Stimulus: assert rst during cycle 2 of MD_WAIT.
  - Response: strobes 0 during rst; after rst, state RUN, stallCount=0, no spurious mdGo.
- Saturation:
  - Stimulus: CNT_W=4; 20 consecutive load-use cycles.
  - Response: stallCount stops at 15.
